// File: rtl/jk_ms_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : jk_ms_pkg
//  Description : Shared definitions for the master-slave JK register bank:
//                cell mode encodings and slave-transfer mode constants.
//  Revision    : 1.0 - initial release
// ============================================================================
package jk_ms_pkg;

   // Per-bank cell behaviour, sampled together with en
   localparam logic [1:0] MODE_JK = 2'b00;
   localparam logic [1:0] MODE_T  = 2'b01;
   localparam logic [1:0] MODE_D  = 2'b10;
   localparam logic [1:0] MODE_SR = 2'b11;

   // Slave-stage transfer policy
   localparam int CM_PIPE   = 0;  // slave follows master every cycle
   localparam int CM_COMMIT = 1;  // slave updates only on commit

endpackage : jk_ms_pkg
`default_nettype wire

// File: rtl/jk_ms_next_state.sv
`default_nettype none
// ============================================================================
//  Module      : jk_ms_next_state
//  Description : Combinational next-state of one storage cell.
//  Ports       : mode       - cell behaviour (JK / T / D / SR)
//                j, k       - J/T/D/S and K/R inputs
//                cur        - present master value of the cell
//                nxt        - next master value if the cell is enabled
//                sr_illegal - S=R=1 presented while in SR mode
//  Revision    : 1.0 - initial release
// ============================================================================
module jk_ms_next_state
   import jk_ms_pkg::*;
(
   input  logic [1:0] mode,
   input  logic       j,
   input  logic       k,
   input  logic       cur,
   output logic       nxt,
   output logic       sr_illegal
);

   always_comb begin
      nxt        = cur;
      sr_illegal = 1'b0;
      case (mode)
         MODE_JK: begin
            case ({j, k})
               2'b01:   nxt = 1'b0;
               2'b10:   nxt = 1'b1;
               2'b11:   nxt = ~cur;
               default: nxt = cur;
            endcase
         end
         MODE_T:  nxt = cur ^ j;
         MODE_D:  nxt = j;
         default: begin  // MODE_SR
            case ({j, k})
               2'b10:   nxt = 1'b1;
               2'b01:   nxt = 1'b0;
               2'b11: begin
                  // Illegal combination: cell holds, caller records the error
                  nxt        = cur;
                  sr_illegal = 1'b1;
               end
               default: nxt = cur;
            endcase
         end
      endcase
   end

endmodule : jk_ms_next_state
`default_nettype wire

// File: rtl/jk_ms_register_bank.sv
`default_nettype none
// ============================================================================
//  Module      : jk_ms_register_bank
//  Description : Bank of WIDTH master-slave JK-style cells with selectable
//                JK/T/D/SR mode, parallel load, pipelined or commit-based
//                slave transfer, saturating change counter and sticky
//                illegal-SR flag.
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                en, mode, j, k    - per-cycle master update controls
//                load, load_data   - parallel master load (beats en)
//                commit            - slave transfer request (commit mode)
//                err_clr           - clears sr_err
//                q, master_q       - slave (visible) and master values
//                pending           - master written since last transfer
//                sr_err            - sticky S=R=1 indicator
//                chg_cnt           - saturating count of changing transfers
//  Revision    : 1.0 - initial release
// ============================================================================
module jk_ms_register_bank
   import jk_ms_pkg::*;
#(
   parameter int               WIDTH       = 8,
   parameter int               COMMIT_MODE = 0,
   parameter logic [WIDTH-1:0] RST_VAL     = {WIDTH{1'b0}},
   parameter int               COUNT_W     = 8
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [1:0]         mode,
   input  logic [WIDTH-1:0]   j,
   input  logic [WIDTH-1:0]   k,
   input  logic               load,
   input  logic [WIDTH-1:0]   load_data,
   input  logic               commit,
   input  logic               err_clr,
   output logic [WIDTH-1:0]   q,
   output logic [WIDTH-1:0]   master_q,
   output logic               pending,
   output logic               sr_err,
   output logic [COUNT_W-1:0] chg_cnt
);

   localparam logic [COUNT_W-1:0] c_cnt_one = {{(COUNT_W-1){1'b0}}, 1'b1};
   localparam logic [COUNT_W-1:0] c_cnt_max = {COUNT_W{1'b1}};

   logic [WIDTH-1:0]   cell_nxt;
   logic [WIDTH-1:0]   cell_ill;

   logic [WIDTH-1:0]   master_d;
   logic [WIDTH-1:0]   slave_q,   slave_d;
   logic               pending_q, pending_d;
   logic               sr_err_q,  sr_err_d;
   logic [COUNT_W-1:0] chg_cnt_q, chg_cnt_d;
   logic               xfer;
   logic               sr_hit;

   generate
      for (genvar i = 0; i < WIDTH; i++) begin : g_cell
         jk_ms_next_state u_ns (
            .mode       (mode),
            .j          (j[i]),
            .k          (k[i]),
            .cur        (master_q[i]),
            .nxt        (cell_nxt[i]),
            .sr_illegal (cell_ill[i])
         );
      end
   endgenerate

   always_comb begin
      // In pipelined mode every cycle is a transfer and commit is a don't-care
      xfer = (COMMIT_MODE == CM_PIPE) ? 1'b1 : commit;

      master_d = master_q;
      if (load)
         master_d = load_data;
      else if (en)
         master_d = cell_nxt;

      // Transfers always see the pre-edge master value
      slave_d = xfer ? master_q : slave_q;

      // A write in the same cycle as a transfer leaves new data outstanding
      pending_d = pending_q;
      if (load || en)
         pending_d = 1'b1;
      else if (xfer)
         pending_d = 1'b0;

      // Illegal SR only counts when the en path is actually taken (load wins)
      sr_hit   = en && !load && (mode == MODE_SR) && (|cell_ill);
      sr_err_d = sr_err_q;
      if (sr_hit)
         sr_err_d = 1'b1;
      else if (err_clr)
         sr_err_d = 1'b0;

      chg_cnt_d = chg_cnt_q;
      if (xfer && (master_q != slave_q) && (chg_cnt_q != c_cnt_max))
         chg_cnt_d = chg_cnt_q + c_cnt_one;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         master_q  <= RST_VAL;
         slave_q   <= RST_VAL;
         pending_q <= 1'b0;
         sr_err_q  <= 1'b0;
         chg_cnt_q <= '0;
      end else begin
         master_q  <= master_d;
         slave_q   <= slave_d;
         pending_q <= pending_d;
         sr_err_q  <= sr_err_d;
         chg_cnt_q <= chg_cnt_d;
      end
   end

   assign q       = slave_q;
   assign pending = pending_q;
   assign sr_err  = sr_err_q;
   assign chg_cnt = chg_cnt_q;

endmodule : jk_ms_register_bank
`default_nettype wire
